// File: rtl/snn_layer_sequencer.sv
// Control FSM and address generator for the SNN inference datapath.
// Walks hidden layer, output layer, then an argmax over the output-unit RAM.
module snn_layer_sequencer #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 32,
    parameter int N_OUT   = 10,
    parameter int ROM_LAT = 1,
    parameter int ACT_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [7:0]                       q_output_unit,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(N_OUT)-1:0]         digit,
    output logic                             layer_sel,
    output logic                             mac_en,
    output logic                             mac_clr,
    output logic [$clog2(N_IN)-1:0]          addr_input_unit,
    output logic [$clog2(N_IN*N_HID)-1:0]    addr_hidden_weight,
    output logic [$clog2(N_HID*N_OUT)-1:0]   addr_output_weight,
    output logic [$clog2(N_HID)-1:0]         addr_hidden_unit,
    output logic [$clog2(N_OUT)-1:0]         addr_output_unit,
    output logic                             we_hidden,
    output logic                             we_output
);
    localparam int IW  = $clog2(N_IN);
    localparam int JW  = $clog2(N_HID);
    localparam int KW  = $clog2(N_OUT);
    localparam int D   = ROM_LAT + ACT_LAT + 1;
    localparam int DCW = $clog2(D + 1);
    localparam int ACW = $clog2(N_OUT + ROM_LAT + 1);

    localparam logic [IW-1:0]  I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0]  J_LAST = JW'(N_HID - 1);
    localparam logic [KW-1:0]  K_LAST = KW'(N_OUT - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(D - 1);
    localparam logic [ACW-1:0] A_LAT  = ACW'(ROM_LAT);
    localparam logic [ACW-1:0] A_LAST = ACW'(N_OUT + ROM_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HID_MAC, S_HID_DRAIN, S_HID_WRITE,
        S_OUT_MAC, S_OUT_DRAIN, S_OUT_WRITE, S_ARGMAX, S_DONE
    } state_t;

    state_t             state;
    logic [DCW-1:0]     dcnt;
    logic [ACW-1:0]     acnt;
    logic [7:0]         max_val;
    logic [KW-1:0]      best;
    logic [KW-1:0]      cand;
    logic               take;
    logic               mac_clr_q;
    logic               issue;
    logic [ROM_LAT-1:0] vld_pipe;

    // The address counters double as the loop indices i, j, k.
    assign issue   = (state == S_HID_MAC) || (state == S_OUT_MAC);
    assign mac_en  = vld_pipe[ROM_LAT-1];
    assign mac_clr = mac_clr_q | ((state == S_IDLE) && start && rst_n);

    // Read data for index acnt-ROM_LAT is present this cycle; first valid sample always seeds the max.
    assign cand = KW'(acnt - A_LAT);
    assign take = (state == S_ARGMAX) && (acnt >= A_LAT) &&
                  ((acnt == A_LAT) || (q_output_unit > max_val));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= ROM_LAT'({vld_pipe, issue});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            digit              <= '0;
            layer_sel          <= 1'b0;
            mac_clr_q          <= 1'b0;
            we_hidden          <= 1'b0;
            we_output          <= 1'b0;
            addr_input_unit    <= '0;
            addr_hidden_weight <= '0;
            addr_output_weight <= '0;
            addr_hidden_unit   <= '0;
            addr_output_unit   <= '0;
            dcnt               <= '0;
            acnt               <= '0;
            max_val            <= '0;
            best               <= '0;
        end else begin
            done      <= 1'b0;
            we_hidden <= 1'b0;
            we_output <= 1'b0;
            mac_clr_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state              <= S_HID_MAC;
                    busy               <= 1'b1;
                    layer_sel          <= 1'b0;
                    addr_input_unit    <= '0;
                    addr_hidden_unit   <= '0;
                    addr_output_unit   <= '0;
                    addr_hidden_weight <= '0;
                    addr_output_weight <= '0;
                end
                S_HID_MAC: begin
                    if (addr_input_unit == I_LAST) begin
                        state <= S_HID_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        addr_input_unit    <= addr_input_unit + 1'b1;
                        addr_hidden_weight <= addr_hidden_weight + 1'b1;
                    end
                end
                S_HID_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        state     <= S_HID_WRITE;
                        we_hidden <= 1'b1;
                        mac_clr_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_HID_WRITE: begin
                    addr_input_unit <= '0;
                    if (addr_hidden_unit == J_LAST) begin
                        state              <= S_OUT_MAC;
                        layer_sel          <= 1'b1;
                        addr_hidden_unit   <= '0;
                        addr_hidden_weight <= '0;
                    end else begin
                        state              <= S_HID_MAC;
                        addr_hidden_unit   <= addr_hidden_unit + 1'b1;
                        addr_hidden_weight <= addr_hidden_weight + 1'b1;
                    end
                end
                S_OUT_MAC: begin
                    if (addr_hidden_unit == J_LAST) begin
                        state <= S_OUT_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        addr_hidden_unit   <= addr_hidden_unit + 1'b1;
                        addr_output_weight <= addr_output_weight + 1'b1;
                    end
                end
                S_OUT_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        state     <= S_OUT_WRITE;
                        we_output <= 1'b1;
                        mac_clr_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_OUT_WRITE: begin
                    addr_hidden_unit <= '0;
                    if (addr_output_unit == K_LAST) begin
                        state              <= S_ARGMAX;
                        addr_output_unit   <= '0;
                        addr_output_weight <= '0;
                        acnt               <= '0;
                    end else begin
                        state              <= S_OUT_MAC;
                        addr_output_unit   <= addr_output_unit + 1'b1;
                        addr_output_weight <= addr_output_weight + 1'b1;
                    end
                end
                S_ARGMAX: begin
                    acnt <= acnt + 1'b1;
                    if (addr_output_unit != K_LAST)
                        addr_output_unit <= addr_output_unit + 1'b1;
                    if (take) begin
                        max_val <= q_output_unit;
                        best    <= cand;
                    end
                    if (acnt == A_LAST) begin
                        state            <= S_DONE;
                        done             <= 1'b1;
                        digit            <= take ? cand : best;
                        addr_output_unit <= '0;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    layer_sel <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench: stimulus pushes the expected digit, a monitor checks strobes, addresses,
// latency and the digit against a first-maximum reference over the modelled output RAM.
module tb_snn_layer_sequencer;
    localparam int N_IN = 784, N_HID = 32, N_OUT = 10, ROM_LAT = 1, ACT_LAT = 2;
    localparam int D    = ROM_LAT + ACT_LAT + 1;
    localparam int LAT  = N_HID*(N_IN+D+1) + N_OUT*(N_HID+D+1) + N_OUT + ROM_LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [7:0]  q_output_unit;
    logic        busy, done, layer_sel, mac_en, mac_clr, we_hidden, we_output;
    logic [3:0]  digit, addr_output_unit;
    logic [9:0]  addr_input_unit;
    logic [14:0] addr_hidden_weight;
    logic [8:0]  addr_output_weight;
    logic [4:0]  addr_hidden_unit;

    logic [7:0]  out_ram [16];
    int          exp_q [$];
    int          checks = 0, failures = 0;
    bit          start_hold = 1'b0, end_req = 1'b0;

    snn_layer_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
                          .ROM_LAT(ROM_LAT), .ACT_LAT(ACT_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_output_unit(q_output_unit),
        .busy(busy), .done(done), .digit(digit), .layer_sel(layer_sel),
        .mac_en(mac_en), .mac_clr(mac_clr), .addr_input_unit(addr_input_unit),
        .addr_hidden_weight(addr_hidden_weight), .addr_output_weight(addr_output_weight),
        .addr_hidden_unit(addr_hidden_unit), .addr_output_unit(addr_output_unit),
        .we_hidden(we_hidden), .we_output(we_output)
    );

    always #5 clk = ~clk;

    // Output-unit RAM with one cycle of read latency.
    initial begin
        q_output_unit = 8'd0;
        forever begin
            @(posedge clk);
            q_output_unit <= out_ram[addr_output_unit];
        end
    end

    function automatic int ref_argmax();
        int b = 0;
        for (int k = 1; k < N_OUT; k++)
            if (out_ram[k] > out_ram[b]) b = k;
        return b;
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Monitor: samples 3 time units after each rising edge.
    initial begin
        longint cyc = 0, s_cyc = 0, last_done = 0;
        longint prev_ai = 0, prev_hw = 0, prev_ow = 0, prev_ahu = 0;
        bit     prev_busy = 0, prev_done = 0, prev_layer = 0;
        bit     active = 0, first_mac = 0, have_done = 0, end_checked = 0;
        int     n_h = 0, n_o = 0, e_i = 0, runs = 0, e;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", longint'({busy, done, digit, layer_sel, mac_en, mac_clr,
                    addr_input_unit, addr_hidden_weight, addr_output_weight, addr_hidden_unit,
                    addr_output_unit, we_hidden, we_output}), 0);
                exp_q.delete();
                active = 0; have_done = 0;
            end else begin
                if (prev_done) chk("busy_low_after_done", busy, 0);
                if (!prev_busy && start) begin
                    chk("busy_rise", busy, 1);
                    if (start_hold && have_done) chk("b2b_start_cycle", cyc, last_done + 2);
                    active = 1; s_cyc = cyc; first_mac = 1;
                    n_h = 0; n_o = 0; e_i = 0;
                end
                if (mac_en) begin
                    chk("mac_en_in_run", active, 1);
                    if (first_mac) chk("first_mac_en_cycle", cyc, s_cyc + ROM_LAT);
                    first_mac = 0;
                    if (!prev_layer) begin
                        chk("hid_input_addr", prev_ai, e_i);
                        chk("hid_weight_addr", prev_hw, n_h*N_IN + e_i);
                    end else begin
                        chk("out_hidden_addr", prev_ahu, e_i);
                        chk("out_weight_addr", prev_ow, n_o*N_HID + e_i);
                    end
                    e_i++;
                end
                if (we_hidden) begin
                    chk("we_hidden_addr", addr_hidden_unit, n_h);
                    chk("we_hidden_mac_clr", mac_clr, 1);
                    chk("we_hidden_layer", layer_sel, 0);
                    chk("hid_mac_count", e_i, N_IN);
                    chk("hid_before_out", n_o, 0);
                    n_h++; e_i = 0;
                end
                if (we_output) begin
                    chk("we_output_addr", addr_output_unit, n_o);
                    chk("we_output_mac_clr", mac_clr, 1);
                    chk("we_output_layer", layer_sel, 1);
                    chk("out_mac_count", e_i, N_HID);
                    chk("hid_writes_before_out", n_h, N_HID);
                    n_o++; e_i = 0;
                end
                if (done) begin
                    chk("done_in_run", active, 1);
                    chk("done_latency", cyc - s_cyc + 1, LAT);
                    chk("busy_during_done", busy, 1);
                    chk("out_write_count", n_o, N_OUT);
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("digit", digit, e);
                    end
                    runs++; active = 0; have_done = 1; last_done = cyc;
                end
            end
            if (end_req && !end_checked) begin
                chk("sb_empty", exp_q.size(), 0);
                chk("runs_completed", runs, 2);
                end_checked = 1;
            end
            prev_busy = busy; prev_done = done; prev_layer = layer_sel;
            prev_ai = addr_input_unit; prev_hw = addr_hidden_weight;
            prev_ow = addr_output_weight; prev_ahu = addr_hidden_unit;
        end
    end

    task automatic wait_done(input int bound);
        for (int n = 0; n <= bound; n++) begin
            @(negedge clk);
            if (done) return;
        end
        $display("FAIL wait_done: no done within %0d cycles", bound);
        $fatal(1, "timeout");
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0;
        for (int k = 0; k < 16; k++) out_ram[k] = 8'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run aborted by an asynchronous reset around cycle 10000.
        for (int k = 0; k < N_OUT; k++) out_ram[k] = 8'($urandom_range(0, 255));
        exp_q.push_back(ref_argmax());
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (9998) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tie pattern: the first 200 wins; random stray start pulses while busy.
        out_ram[0] = 8'd3; out_ram[1] = 8'd9; out_ram[2] = 8'd200;
        out_ram[3] = 8'd7; out_ram[4] = 8'd200; out_ram[5] = 8'd0;
        for (int k = 6; k < N_OUT; k++) out_ram[k] = 8'($urandom_range(0, 199));
        exp_q.push_back(ref_argmax());
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int p = 0; p < 6; p++) begin
            repeat ($urandom_range(100, 3000)) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        start = 1'b1; start_hold = 1'b1;
        wait_done(LAT + 100);

        // Back-to-back run with start still held, all-zero RAM.
        for (int k = 0; k < 16; k++) out_ram[k] = 8'd0;
        exp_q.push_back(ref_argmax());
        wait_done(LAT + 100);
        start = 1'b0; start_hold = 1'b0;

        repeat (5) @(negedge clk);
        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
